ikaopll_write_sequencer: RTL and testbench
==========================================

IKAOPLL_WRITE_SEQUENCER -- requirements
Module: ikaopll_write_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, number of queued register writes (power of two, 2..32).
REQ-002 SHALL have parameter STROBE_LEN, default 2, CS_n/WR_n low time in phiM enables (1..15).
REQ-003 SHALL have parameter ADDR_WAIT, default 12, idle phiM enables after an address strobe (1..255).
REQ-004 SHALL have parameter DATA_WAIT, default 84, idle phiM enables after a data strobe (1..255).
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 i_EMUCLK  in  1  emulator master clock, the only clock.
REQ-007 i_RST  in  1  synchronous active-high reset.
REQ-008 i_phiM_PCEN_n  in  1  phiM enable, negative logic; all timing advances only when low.
REQ-009 i_REQ_VALID  in  1  requester offers one register write.
REQ-010 o_REQ_READY  out  1  queue can accept; transfer on VALID&READY at a clock edge.
REQ-011 i_REQ_ADDR  in  8  OPLL register address.
REQ-012 i_REQ_DATA  in  8  OPLL register data.
REQ-013 o_CS_n, o_WR_n, o_A0  out  1 each  OPLL bus control, registered.
REQ-014 o_D  out  8  OPLL bus data, registered.
REQ-015 o_BUSY  out  1  queue not empty or FSM not IDLE.
REQ-016 o_LEVEL  out  $clog2(FIFO_DEPTH)+1  queued entry count.

Function
REQ-017 SHALL accept on every edge with VALID&READY regardless of phiM enable; READY=(LEVEL<FIFO_DEPTH), no bypass when full.
REQ-018 SHALL run FSM IDLE->ADDR_STB->ADDR_WAIT->DATA_STB->DATA_WAIT->IDLE; transitions only on edges with i_phiM_PCEN_n=0.
REQ-019 IDLE with LEVEL>0 on an enabled edge SHALL pop head entry, enter ADDR_STB, drive CS_n=0, WR_n=0, A0=0, D=addr.
REQ-020 ADDR_STB SHALL hold outputs STROBE_LEN enabled edges, then drive CS_n=1, WR_n=1 and enter ADDR_WAIT.
REQ-021 ADDR_WAIT SHALL last ADDR_WAIT enabled edges, then enter DATA_STB with CS_n=0, WR_n=0, A0=1, D=data.
REQ-022 DATA_STB SHALL hold STROBE_LEN enabled edges, then release CS_n/WR_n, enter DATA_WAIT for DATA_WAIT enabled edges, then IDLE.
REQ-023 o_D SHALL hold its last value while CS_n=1; A0 changes only together with CS_n falling.
REQ-024 Entries SHALL be issued strictly in acceptance order; push and pop on the same edge keep LEVEL unchanged.
REQ-025 Wait counter SHALL be 8-bit down-counter loaded at state entry; no wrap past zero.
REQ-026 DATA_WAIT->IDLE->next ADDR_STB SHALL cost exactly one extra enabled edge (IDLE pop edge).

Reset
REQ-027 i_RST SHALL, on its edge, force IDLE, CS_n=1, WR_n=1, A0=0, D=0x00, LEVEL=0, READY=0 during reset, BUSY=0; READY=1 the edge after release.
REQ-028 Reset mid-strobe SHALL abort the transaction and flush the queue; aborted write is lost, no partial retry.

Configuration
REQ-029 Macro IKAOPLL_WRSEQ_ADDR_SKIP_EN SHALL, when defined, skip ADDR_STB/ADDR_WAIT when popped addr equals last issued addr (IDLE->DATA_STB directly).
REQ-030 Last-addr cache SHALL be invalidated by reset; undefined macro: every write issues both phases; cache logic absent.

Structure
REQ-031 Shared package ikaopll_pkg SHALL hold FSM state enum and default timing constants (12, 84, 2).
REQ-032 Queue SHALL be sub-module ikaopll_wrseq_fifo (sync FIFO, width 16, level output); FSM and counters in top.

Verification
REQ-033 phiM enable every 4th clock; push (0x10,0x55) -> CS_n low 2 enables A0=0 D=0x10, 12 idle, 2 enables A0=1 D=0x55, 84 idle, BUSY=0.
REQ-034 Push 9 entries back-to-back, depth 8 -> READY low after 8th (first not yet popped), 9th accepted after first pop; bus order matches push order.
REQ-035 Assert i_RST during DATA_STB with 3 queued -> next edge CS_n=1, WR_n=1, LEVEL=0; no further strobes.
REQ-036 i_phiM_PCEN_n held high 100 clocks mid ADDR_WAIT -> bus frozen, counter unchanged; resumes exactly where paused.
REQ-037 With IKAOPLL_WRSEQ_ADDR_SKIP_EN: writes (0x20,0x01),(0x20,0x02),(0x21,0x03) -> address strobes for 0x20 once and 0x21 once, three data strobes.

Source files
------------

// File: rtl/ikaopll_pkg.sv
// Shared types and default bus timing for the OPLL write sequencer.
package ikaopll_pkg;

    localparam int unsigned DEF_STROBE_LEN = 2;
    localparam int unsigned DEF_ADDR_WAIT  = 12;
    localparam int unsigned DEF_DATA_WAIT  = 84;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR_STB,
        ST_ADDR_WAIT,
        ST_DATA_STB,
        ST_DATA_WAIT
    } wrseq_state_e;

    // Wait counters stop at zero instead of wrapping.
    function automatic logic [7:0] sat_dec(input logic [7:0] c);
        return (c == 8'd0) ? 8'd0 : c - 8'd1;
    endfunction

endpackage

// File: rtl/ikaopll_wrseq_fifo.sv
// Synchronous FIFO holding queued {addr, data} register writes, with fill level.
module ikaopll_wrseq_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             push_ok, pop_ok;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push_ok && !pop_ok)      level_d = level_q + LW'(1);
        else if (pop_ok && !push_ok) level_d = level_q - LW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/ikaopll_write_sequencer.sv
// Queues OPLL register writes and replays them as paced address/data bus strobes on phiM enables.
// Optional IKAOPLL_WRSEQ_ADDR_SKIP_EN: skip the address phase when the address repeats.
module ikaopll_write_sequencer
    import ikaopll_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned STROBE_LEN = DEF_STROBE_LEN,
    parameter int unsigned ADDR_WAIT  = DEF_ADDR_WAIT,
    parameter int unsigned DATA_WAIT  = DEF_DATA_WAIT
) (
    input  logic                         i_EMUCLK,
    input  logic                         i_RST,
    input  logic                         i_phiM_PCEN_n,
    input  logic                         i_REQ_VALID,
    output logic                         o_REQ_READY,
    input  logic [7:0]                   i_REQ_ADDR,
    input  logic [7:0]                   i_REQ_DATA,
    output logic                         o_CS_n,
    output logic                         o_WR_n,
    output logic                         o_A0,
    output logic [7:0]                   o_D,
    output logic                         o_BUSY,
    output logic [$clog2(FIFO_DEPTH):0]  o_LEVEL
);

    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

    wrseq_state_e state_q, state_d;
    logic [7:0]   cnt_q, cnt_d;
    logic         cs_q, cs_d, wr_q, wr_d, a0_q, a0_d;
    logic [7:0]   d_q, d_d, data_q, data_d;
    logic         rdy_en_q, rdy_en_d;

    logic         fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [15:0]  fifo_rd_data;
    logic [LW-1:0] fifo_level;
    logic         ready;
    logic         addr_hit;

    ikaopll_wrseq_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16),
        .LW    (LW)
    ) u_fifo (
        .clk     (i_EMUCLK),
        .rst     (i_RST),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data ({i_REQ_ADDR, i_REQ_DATA}),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // READY stays low through reset and rises on the first edge after release.
    assign ready       = rdy_en_q && !fifo_full;
    assign fifo_push   = i_REQ_VALID && ready;
    assign o_REQ_READY = ready;
    assign o_CS_n      = cs_q;
    assign o_WR_n      = wr_q;
    assign o_A0        = a0_q;
    assign o_D         = d_q;
    assign o_LEVEL     = fifo_level;
    assign o_BUSY      = !fifo_empty || (state_q != ST_IDLE);
    assign rdy_en_d    = 1'b1;

`ifdef IKAOPLL_WRSEQ_ADDR_SKIP_EN
    logic [7:0] last_addr_q, last_addr_d;
    logic       last_vld_q, last_vld_d;

    assign addr_hit = last_vld_q && (last_addr_q == fifo_rd_data[15:8]);

    always_comb begin
        last_addr_d = last_addr_q;
        last_vld_d  = last_vld_q;
        if (fifo_pop) begin
            last_addr_d = fifo_rd_data[15:8];
            last_vld_d  = 1'b1;
        end
    end

    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            last_addr_q <= '0;
            last_vld_q  <= 1'b0;
        end else begin
            last_addr_q <= last_addr_d;
            last_vld_q  <= last_vld_d;
        end
    end
`else
    assign addr_hit = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cs_d     = cs_q;
        wr_d     = wr_q;
        a0_d     = a0_q;
        d_d      = d_q;
        data_d   = data_q;
        fifo_pop = 1'b0;
        if (!i_phiM_PCEN_n) begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        data_d   = fifo_rd_data[7:0];
                        cs_d     = 1'b0;
                        wr_d     = 1'b0;
                        cnt_d    = 8'(STROBE_LEN);
                        if (addr_hit) begin
                            state_d = ST_DATA_STB;
                            a0_d    = 1'b1;
                            d_d     = fifo_rd_data[7:0];
                        end else begin
                            state_d = ST_ADDR_STB;
                            a0_d    = 1'b0;
                            d_d     = fifo_rd_data[15:8];
                        end
                    end
                end
                ST_ADDR_STB: begin
                    if (cnt_q <= 8'd1) begin
                        state_d = ST_ADDR_WAIT;
                        cs_d    = 1'b1;
                        wr_d    = 1'b1;
                        cnt_d   = 8'(ADDR_WAIT);
                    end else begin
                        cnt_d = sat_dec(cnt_q);
                    end
                end
                ST_ADDR_WAIT: begin
                    if (cnt_q <= 8'd1) begin
                        state_d = ST_DATA_STB;
                        cs_d    = 1'b0;
                        wr_d    = 1'b0;
                        a0_d    = 1'b1;
                        d_d     = data_q;
                        cnt_d   = 8'(STROBE_LEN);
                    end else begin
                        cnt_d = sat_dec(cnt_q);
                    end
                end
                ST_DATA_STB: begin
                    if (cnt_q <= 8'd1) begin
                        state_d = ST_DATA_WAIT;
                        cs_d    = 1'b1;
                        wr_d    = 1'b1;
                        cnt_d   = 8'(DATA_WAIT);
                    end else begin
                        cnt_d = sat_dec(cnt_q);
                    end
                end
                ST_DATA_WAIT: begin
                    if (cnt_q <= 8'd1) state_d = ST_IDLE;
                    else               cnt_d   = sat_dec(cnt_q);
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            cs_q     <= 1'b1;
            wr_q     <= 1'b1;
            a0_q     <= 1'b0;
            d_q      <= '0;
            data_q   <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cs_q     <= cs_d;
            wr_q     <= wr_d;
            a0_q     <= a0_d;
            d_q      <= d_d;
            data_q   <= data_d;
            rdy_en_q <= rdy_en_d;
        end
    end

endmodule

// File: tb/tb_ikaopll_write_sequencer.sv
// Scoreboard bench for ikaopll_write_sequencer: accepted writes become expected bus strobes.
module tb_ikaopll_write_sequencer;

    localparam int DEPTH = 8;
    localparam int SL    = 2;
    localparam int AWT   = 12;
    localparam int DWT   = 84;

    logic       clk;
    logic       rst, pcen_n, valid;
    logic [7:0] addr, data;
    logic       ready, cs_n, wr_n, a0, busy;
    logic [7:0] dbus;
    logic [3:0] level;

    ikaopll_write_sequencer #(
        .FIFO_DEPTH (DEPTH),
        .STROBE_LEN (SL),
        .ADDR_WAIT  (AWT),
        .DATA_WAIT  (DWT)
    ) dut (
        .i_EMUCLK      (clk),
        .i_RST         (rst),
        .i_phiM_PCEN_n (pcen_n),
        .i_REQ_VALID   (valid),
        .o_REQ_READY   (ready),
        .i_REQ_ADDR    (addr),
        .i_REQ_DATA    (data),
        .o_CS_n        (cs_n),
        .o_WR_n        (wr_n),
        .o_A0          (a0),
        .o_D           (dbus),
        .o_BUSY        (busy),
        .o_LEVEL       (level)
    );

    typedef struct packed {
        logic       a0;
        logic [7:0] d;
        logic       first;
    } strb_t;

    strb_t      exp_q[$];
    int         total = 0, bad = 0;
    int         n_acc = 0, n_pop = 0, n_strb = 0;
    bit         started = 0, edge_en = 0, edge_rst = 0, ready_pre = 0, freeze = 0;
    bit         last_v = 0;
    logic [7:0] last_a = 8'h00;

    // Monitor tracking state
    logic       cs_p = 1'b1, a0_p = 1'b0, busy_p = 1'b0;
    logic [7:0] d_p = 8'h00;
    int         gap = 0, low = 0, last_ph = 0, cur_ph = 0;
    bit         fall, rise;
    strb_t      e;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp_v, $time);
        end
    endtask

    task automatic tmo(input string nm);
        total++;
        bad++;
        $display("FAIL %s actual=timeout expected=event t=%0t", nm, $time);
    endtask

    // phiM enable: one clock in four, forced off while frozen
    initial begin
        int ph;
        ph = 0;
        pcen_n = 1'b1;
        forever begin
            @(posedge clk);
            #3;
            ph = (ph + 1) % 4;
            pcen_n = freeze ? 1'b1 : (ph != 0);
        end
    end

    // Acceptance side: every accepted write becomes its expected strobes
    always @(posedge clk) begin
        #1;
        edge_en  = !pcen_n;
        edge_rst = rst;
        if (rst) begin
            last_v = 0;
        end else if (valid && ready_pre) begin
`ifdef IKAOPLL_WRSEQ_ADDR_SKIP_EN
            if (last_v && last_a == addr) begin
                exp_q.push_back('{a0: 1'b1, d: data, first: 1'b1});
            end else begin
                exp_q.push_back('{a0: 1'b0, d: addr, first: 1'b1});
                exp_q.push_back('{a0: 1'b1, d: data, first: 1'b0});
            end
`else
            exp_q.push_back('{a0: 1'b0, d: addr, first: 1'b1});
            exp_q.push_back('{a0: 1'b1, d: data, first: 1'b0});
`endif
            last_a = addr;
            last_v = 1;
            n_acc++;
        end
        ready_pre = ready;
    end

    // Monitor: observes the bus each cycle and compares against the scoreboard
    always @(negedge clk) begin
        if (edge_rst) begin
            started = 1;
            chk("rst_cs", int'(cs_n), 1);
            chk("rst_wr", int'(wr_n), 1);
            chk("rst_a0", int'(a0), 0);
            chk("rst_d", int'(dbus), 0);
            chk("rst_level", int'(level), 0);
            chk("rst_ready", int'(ready), 0);
            chk("rst_busy", int'(busy), 0);
            exp_q.delete();
            n_pop = n_acc;
            cs_p = 1'b1; a0_p = 1'b0; d_p = 8'h00; busy_p = 1'b0;
            gap = 0; low = 0; last_ph = 0; cur_ph = 0;
        end else if (started) begin
            fall = cs_p && !cs_n;
            rise = !cs_p && cs_n;
            if (edge_en) begin
                gap++;
                low++;
            end
            chk("wr_follows_cs", int'(wr_n), int'(cs_n));
            if (!edge_en) chk("cs_frozen", int'(cs_n), int'(cs_p));
            if (!fall) chk("a0_d_hold", int'({a0, dbus}), int'({a0_p, d_p}));
            if (fall) begin
                n_strb++;
                if (exp_q.size() == 0) begin
                    tmo("spurious_strobe");
                end else begin
                    e = exp_q.pop_front();
                    chk("strobe_a0_d", int'({a0, dbus}), int'({e.a0, e.d}));
                    if (e.first) n_pop++;
                end
                if (last_ph == 1) chk("addr_wait_len", gap, AWT);
                if (last_ph == 2) begin
                    total++;
                    if (gap < DWT + 1) begin
                        bad++;
                        $display("FAIL data_wait_len actual=%0d expected>=%0d", gap, DWT + 1);
                    end
                end
                low = 0;
                cur_ph = a0 ? 2 : 1;
            end
            if (rise) begin
                chk("strobe_len", low, SL);
                gap = 0;
                last_ph = cur_ph;
            end
            if (busy_p && !busy) begin
                chk("busy_fall_phase", last_ph, 2);
                chk("busy_fall_gap", gap, DWT);
            end
            chk("level", int'(level), n_acc - n_pop);
            chk("ready", int'(ready), int'((n_acc - n_pop) < DEPTH));
            cs_p = cs_n; a0_p = a0; d_p = dbus; busy_p = busy;
        end
    end

    task automatic clks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] dv);
        addr = a;
        data = dv;
        valid = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if (ready) begin
                @(posedge clk);
                #2;
                valid = 1'b0;
                return;
            end
            @(posedge clk);
            #2;
        end
        valid = 1'b0;
        tmo("push_timeout");
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 12000; i++) begin
            if (!busy) return;
            @(posedge clk);
            #2;
        end
        tmo(nm);
    endtask

    task automatic wait_bus(input logic want_cs, input logic want_a0, input string nm);
        for (int i = 0; i < 4000; i++) begin
            if (cs_n == want_cs && (want_cs || a0 == want_a0)) return;
            @(posedge clk);
            #2;
        end
        tmo(nm);
    endtask

    initial begin
        int         s0;
        logic [8:0] snap;
        rst = 1'b1; valid = 1'b0; addr = 8'h00; data = 8'h00;
        clks(3);
        rst = 1'b0;
        clks(2);

        // single write with full timing
        s0 = n_strb;
        push(8'h10, 8'h55);
        wait_idle("t1_idle");
        chk("t1_strobes", n_strb - s0, 2);

        // bus and counter frozen while phiM enable is held off mid address wait
        push(8'h33, 8'h44);
        wait_bus(1'b0, 1'b0, "t2_addr_stb");
        wait_bus(1'b1, 1'b0, "t2_addr_wait");
        clks(9);
        snap = {cs_n, dbus};
        freeze = 1;
        clks(100);
        chk("t2_frozen_bus", int'({cs_n, dbus}), int'(snap));
        freeze = 0;
        wait_idle("t2_idle");

        // queue full: ninth write waits for the first pop
        freeze = 1;
        clks(2);
        for (int i = 0; i < 8; i++) push(8'(8'h40 + i), 8'(8'hA0 + i));
        chk("t3_full_level", int'(level), 8);
        chk("t3_full_ready", int'(ready), 0);
        freeze = 0;
        push(8'h48, 8'hA8);
        wait_idle("t3_idle");

        // reset during a data strobe with three queued
        for (int i = 0; i < 4; i++) push(8'(8'h60 + i), 8'(8'hB0 + i));
        wait_bus(1'b0, 1'b1, "t4_data_stb");
        chk("t4_pre_level", int'(level), 3);
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        chk("t4_cs", int'(cs_n), 1);
        chk("t4_wr", int'(wr_n), 1);
        chk("t4_level", int'(level), 0);
        s0 = n_strb;
        clks(600);
        chk("t4_no_strobes", n_strb - s0, 0);
        chk("t4_busy", int'(busy), 0);

        // repeated address; only collapses when the skip feature is built in
        s0 = n_strb;
        push(8'h20, 8'h01);
        push(8'h20, 8'h02);
        push(8'h21, 8'h03);
        wait_idle("t5_idle");
`ifdef IKAOPLL_WRSEQ_ADDR_SKIP_EN
        chk("t5_strobes", n_strb - s0, 5);
`else
        chk("t5_strobes", n_strb - s0, 6);
`endif

        // randomized traffic
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 3) == 0) clks($urandom_range(100, 700));
            else                           clks($urandom_range(0, 3));
            push(8'(8'h20 + $urandom_range(0, 3)), 8'($urandom));
        end
        wait_idle("rand_idle");
        clks(4);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
